keypad_encoder: RTL

Front end of the microwave controller's time-entry path. Synchronizes and debounces the raw 10-key one-hot keypad, rejects bounce and multi-key presses, and produces one BCD digit plus a single-cycle strobe per clean keypress. The `controler` block consumes the strobe and digit and shifts them into its minutes/seconds registers. Runs on the 100 Hz system clock (10 ms period).

---
 rtl/keypad_encoder_pkg.sv | 35 +++
 rtl/keypad_encoder_sync2.sv | 33 +++
 rtl/keypad_encoder.sv | 113 +++++++++++
 3 files changed

// File: rtl/keypad_encoder_pkg.sv
// rtl/keypad_encoder_pkg.sv - shared widths, FSM states and keypad helper functions
package keypad_encoder_pkg;

  localparam int KEYPAD_W            = 10;
  localparam int DIGIT_W             = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_DEB_PRESS   = 2'd1,
    ST_HELD        = 2'd2,
    ST_DEB_RELEASE = 2'd3
  } kp_state_e;

  // Exactly one key down
  function automatic logic is_onehot(input logic [KEYPAD_W-1:0] v);
    return (v != '0) && ((v & (v - KEYPAD_W'(1))) == '0);
  endfunction

  // Two or more keys down at once
  function automatic logic is_multi(input logic [KEYPAD_W-1:0] v);
    return (v & (v - KEYPAD_W'(1))) != '0;
  endfunction

  // One-hot bit position to BCD; only meaningful for one-hot input
  function automatic logic [DIGIT_W-1:0] onehot_to_bcd(input logic [KEYPAD_W-1:0] v);
    logic [DIGIT_W-1:0] r;
    r = '0;
    for (int i = 0; i < KEYPAD_W; i++) begin
      if (v[i]) r = DIGIT_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/keypad_encoder_sync2.sv
// rtl/keypad_encoder_sync2.sv - two-flop synchronizer, async active-low reset to 0
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;

  // Shift the raw value one stage per clock
  always_comb begin
    s1_d = din;
    s2_d = s1_q;
  end

  // Synchronizer stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign dout = s2_q;

endmodule

// File: rtl/keypad_encoder.sv
// rtl/keypad_encoder.sv - debounced one-hot keypad to BCD digit with single-cycle strobe
module keypad_encoder
  import keypad_encoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                clearn,
  input  logic [KEYPAD_W-1:0] keypad,
  input  logic                enable,
  output logic [DIGIT_W-1:0]  digit,
  output logic                digit_valid,
  output logic                key_held,
  output logic                multi_key
);

  localparam logic [3:0] DEB_LIM = 4'(DEBOUNCE_CYCLES);

  logic [KEYPAD_W-1:0] ks;

  kp_state_e           state_q, state_d;
  logic [KEYPAD_W-1:0] cand_q, cand_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [DIGIT_W-1:0]  digit_q, digit_d;
  logic                digit_valid_q, digit_valid_d;
  logic                key_held_q, key_held_d;
  logic                multi_key_q, multi_key_d;

  sync2 #(.WIDTH(KEYPAD_W)) u_sync (
    .clk   (clk),
    .rst_n (clearn),
    .din   (keypad),
    .dout  (ks)
  );

  // Debounce FSM: press must hold the same single key, release must hold all-zero
  always_comb begin
    state_d       = state_q;
    cand_d        = cand_q;
    cnt_d         = cnt_q;
    digit_d       = digit_q;
    digit_valid_d = 1'b0;
    multi_key_d   = is_multi(ks);
    case (state_q)
      ST_IDLE: begin
        if (is_onehot(ks)) begin
          cand_d  = ks;
          cnt_d   = 4'd1;
          state_d = ST_DEB_PRESS;
        end
      end
      ST_DEB_PRESS: begin
        if (ks == cand_q) begin
          if (cnt_q < DEB_LIM) begin
            cnt_d = cnt_q + 4'd1;
          end else begin
            state_d = ST_HELD;
            // enable only gates the strobe; the key is still consumed
            if (enable) begin
              digit_d       = onehot_to_bcd(cand_q);
              digit_valid_d = 1'b1;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HELD: begin
        if (ks == '0) begin
          cnt_d   = 4'd1;
          state_d = ST_DEB_RELEASE;
        end
      end
      ST_DEB_RELEASE: begin
        if (ks == '0) begin
          if (cnt_q < DEB_LIM) cnt_d = cnt_q + 4'd1;
          else                 state_d = ST_IDLE;
        end else begin
          state_d = ST_HELD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    key_held_d = (state_d == ST_HELD) || (state_d == ST_DEB_RELEASE);
  end

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      state_q       <= ST_IDLE;
      cand_q        <= '0;
      cnt_q         <= '0;
      digit_q       <= '0;
      digit_valid_q <= 1'b0;
      key_held_q    <= 1'b0;
      multi_key_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cand_q        <= cand_d;
      cnt_q         <= cnt_d;
      digit_q       <= digit_d;
      digit_valid_q <= digit_valid_d;
      key_held_q    <= key_held_d;
      multi_key_q   <= multi_key_d;
    end
  end

  assign digit       = digit_q;
  assign digit_valid = digit_valid_q;
  assign key_held    = key_held_q;
  assign multi_key   = multi_key_q;

endmodule
